// File: rtl/counter_step_controller.sv
// counter_step_controller
// Turns raw active-low push buttons into clean single-cycle load / count-enable
// strobes for a loadable counter. Supports manual single-step, free-running
// auto-count, and an optional halt when the counter reaches all-ones.
module counter_step_controller #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             stop_en,
  input  logic [WIDTH-1:0] q_in,
  output logic             load_n,
  output logic [WIDTH-1:0] d_out,
  output logic             step,
  output logic             running,
  output logic [1:0]       state
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned PS_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      deb;
  logic [2:0]      deb_dly;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [4];

  state_t          fsm_state;
  state_t          ret_state;
  logic [PS_W-1:0] prescale;

  state_t          nxt_state;
  state_t          nxt_ret;
  logic [PS_W-1:0] nxt_prescale;
  logic            nxt_load_n;
  logic [WIDTH-1:0] nxt_d;
  logic            nxt_step;

  logic            ev_load;
  logic            ev_run;
  logic            ev_step;
  logic            tick;

  // Synchronise, debounce and edge-detect the push buttons.
  // The press pulse is taken from a delayed copy of the debounced level so the
  // event is registered one cycle after the level flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '1;
      sync2   <= '1;
      deb     <= '1;
      deb_dly <= '1;
      press   <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      deb_dly <= deb[2:0];
      press   <= deb_dly & ~deb[2:0];
      for (int unsigned k = 0; k < 4; k++) begin
        if (sync2[k] != deb[k]) begin
          if (db_cnt[k] == DB_W'(DEBOUNCE - 1)) begin
            deb[k]    <= ~deb[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + DB_W'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign ev_load = press[1];
  assign ev_run  = press[2];
  assign ev_step = press[0];
  assign tick    = (prescale == PS_W'(TICK_DIV - 1));

  // Next-state and next-output decode; if/else chain gives load > run > step.
  always_comb begin
    nxt_state    = fsm_state;
    nxt_ret      = ret_state;
    nxt_prescale = prescale;
    nxt_load_n   = 1'b1;
    nxt_d        = d_out;
    nxt_step     = 1'b0;
    case (fsm_state)
      IDLE: begin
        if (ev_load) begin
          nxt_state  = LOAD;
          nxt_ret    = IDLE;
          nxt_load_n = 1'b0;
          nxt_d      = sw_data;
        end else if (ev_run) begin
          nxt_state    = RUN;
          nxt_prescale = '0;
        end else if (ev_step) begin
          nxt_step = 1'b1;
        end
      end
      RUN: begin
        if (ev_load) begin
          nxt_state  = LOAD;
          nxt_ret    = RUN;
          nxt_load_n = 1'b0;
          nxt_d      = sw_data;
        end else if (ev_run) begin
          nxt_state    = IDLE;
          nxt_prescale = '0;
        end else if (tick) begin
          nxt_prescale = '0;
          if (stop_en && (q_in == '1)) begin
            nxt_state = IDLE;
          end else begin
            nxt_step = 1'b1;
          end
        end else begin
          nxt_prescale = prescale + PS_W'(1);
        end
      end
      LOAD: begin
        nxt_state    = ret_state;
        nxt_prescale = '0;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state <= IDLE;
      ret_state <= IDLE;
      prescale  <= '0;
      load_n    <= 1'b1;
      d_out     <= '0;
      step      <= 1'b0;
      running   <= 1'b0;
    end else begin
      fsm_state <= nxt_state;
      ret_state <= nxt_ret;
      prescale  <= nxt_prescale;
      load_n    <= nxt_load_n;
      d_out     <= nxt_d;
      step      <= nxt_step;
      running   <= (nxt_state == RUN);
    end
  end

  assign state = fsm_state;

endmodule
